// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU time-sharing controller: ALU op codes,
// FSM state encoding and a small pointer helper.
package alu_share_ctrl_pkg;

  localparam logic [3:0] EXE_ALU_ADD = 4'h0;
  localparam logic [3:0] EXE_ALU_SUB = 4'h1;
  localparam logic [3:0] EXE_ALU_AND = 4'h2;
  localparam logic [3:0] EXE_ALU_OR  = 4'h3;
  localparam logic [3:0] EXE_ALU_XOR = 4'h4;
  localparam logic [3:0] EXE_ALU_SLT = 4'h5;
  localparam logic [3:0] EXE_ALU_SLL = 4'h6;
  localparam logic [3:0] EXE_ALU_SRL = 4'h7;
  localparam logic [3:0] EXE_ALU_SRA = 4'h8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_EXEC = S_EXEC,
    ST_RESP = S_RESP
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the pointer,
// wrapping around; returns the one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int  pos;
  logic hit;

  // scan requesters starting from the pointer, first hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    hit   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos        = (int'(ptr) + off) % NUM_REQ;
      hit        = !any && req[pos];
      grant[pos] = grant[pos] | hit;
      idx        = hit ? IDX_W'(pos) : idx;
      any        = any | hit;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU among NUM_REQ requesters with
// round-robin arbitration and a single op in flight (IDLE -> EXEC -> RESP).
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_oper,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_oper,
  input  logic [31:0]            alu_result,
  input  logic                   alu_overflow,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_overflow,
  output logic                   busy
);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic               take;
  logic               done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // next-state logic; the grant is only offered while idle and out of reset
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    take      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any && !rst) begin
          req_ready = arb_grant;
          take      = 1'b1;
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[gnt_idx]) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, granted index and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      if (take) gnt_idx <= arb_idx;
      if (done) ptr <= IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
    end
  end

  // operand latch doubles as the ALU drive; holds between ops to avoid toggling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      alu_oper <= 4'd0;
    end else if (take) begin
      alu_a    <= req_a[int'(arb_idx)*32 +: 32];
      alu_b    <= req_b[int'(arb_idx)*32 +: 32];
      alu_oper <= req_oper[int'(arb_idx)*4 +: 4];
    end
  end

  // capture ALU output at the end of EXEC and present it until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= '0;
      rsp_result   <= 32'd0;
      rsp_overflow <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_valid    <= NUM_REQ'(1) << gnt_idx;
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow;
    end else if (done) begin
      rsp_valid    <= '0;
    end
  end

endmodule
